// File: rtl/serial_word_deserializer.sv
// serial_word_deserializer
// Collects an LSB-first serial stream into N-bit words. A frame marker aligns
// the word boundaries. Each completed word is presented on a registered
// parallel output, together with a one-cycle valid strobe. A frame marker
// that arrives before the current word is complete raises a one-cycle error
// pulse, and that bit starts the new word.
module serial_word_deserializer #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         sdi,
    input  logic         en,
    input  logic         frame,
    output logic [N-1:0] data_out,
    output logic         data_valid,
    output logic         busy,
    output logic         frame_err
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   sr_q, sr_d;
    logic [N-1:0]   sr_shifted;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   data_out_q, data_out_d;
    logic           data_valid_q, data_valid_d;
    logic           frame_err_q, frame_err_d;

    // The newest bit enters at the MSB, so the first bit of a word
    // ends up in bit 0 after N shifts.
    genvar gi;
    generate
        for (gi = 0; gi < N - 1; gi++) begin : g_shift
            assign sr_shifted[gi] = sr_q[gi + 1];
        end
    endgenerate
    assign sr_shifted[N-1] = sdi;

    // Next-state logic. Every state is held unless a bit event (en=1) occurs.
    // The strobes default low, so each of them lasts exactly one cycle.
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (en) begin
            case (state_q)
                IDLE: begin
                    // Bits that arrive without a frame marker are dropped.
                    if (frame) begin
                        sr_d    = sr_shifted;
                        cnt_d   = CNT_ONE;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    sr_d = sr_shifted;
                    if (frame) begin
                        // A restart discards the partial word. This bit becomes bit 0.
                        cnt_d       = CNT_ONE;
                        frame_err_d = 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        data_out_d   = sr_shifted;
                        data_valid_d = 1'b1;
                        cnt_d        = '0;
                        state_d      = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers. They clear as soon as reset_n falls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            cnt_q        <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q == SHIFT);

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed testbench for serial_word_deserializer with N=4.
// After each clock edge the bench compares {data_valid, busy, frame_err, data_out}
// against a hand-computed expected vector: bit 6 = data_valid, bit 5 = busy,
// bit 4 = frame_err, bits 3:0 = data_out.
module tb_serial_word_deserializer;

    logic       clk;
    logic       reset_n;
    logic       sdi;
    logic       en;
    logic       frame;
    logic [3:0] data_out;
    logic       data_valid;
    logic       busy;
    logic       frame_err;

    int errors = 0;
    int checks = 0;

    serial_word_deserializer #(.N(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sdi        (sdi),
        .en         (en),
        .frame      (frame),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only. Inputs are applied at the falling edge. The task returns
    // 1 time unit after the following rising edge, when the outputs have settled.
    task automatic drive_cycle(input logic f, input logic s, input logic e);
        @(negedge clk);
        frame = f;
        sdi   = s;
        en    = e;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        reset_n = 1'b0;
        frame   = 1'b0;
        sdi     = 1'b0;
        en      = 1'b0;
        #2;
        obs = {data_valid, busy, frame_err, data_out};
        checks++;
        if (obs !== 7'h00) begin
            $display("FAIL reset_async: got=%h expected=%h", obs, 7'h00);
            errors++;
        end
        // The block must stay in reset even while it sees framed bits.
        drive_cycle(1'b1, 1'b1, 1'b1);
        drive_cycle(1'b0, 1'b1, 1'b1);
        obs = {data_valid, busy, frame_err, data_out};
        checks++;
        if (obs !== 7'h00) begin
            $display("FAIL reset_held: got=%h expected=%h", obs, 7'h00);
            errors++;
        end
        $display("reset: dv=%b busy=%b fe=%b data=%h", data_valid, busy, frame_err, data_out);
        @(negedge clk);
        reset_n = 1'b1;
        frame   = 1'b0;
        en      = 1'b0;
    endtask

    // Single word: bits 0,1,0,1 -> 4'hA.
    task automatic test_basic();
        logic [4:0] f_v = 5'b00001;
        logic [4:0] s_v = 5'b01010;
        logic [4:0] e_v = 5'b11111;
        logic [6:0] exp_v [0:4];
        logic [6:0] obs;
        exp_v = '{7'h20, 7'h20, 7'h20, 7'h4A, 7'h0A};
        for (int i = 0; i < 5; i++) begin
            drive_cycle(f_v[i], s_v[i], e_v[i]);
            obs = {data_valid, busy, frame_err, data_out};
            $display("basic c%0d f=%b s=%b e=%b -> dv=%b busy=%b fe=%b data=%h",
                     i, f_v[i], s_v[i], e_v[i], data_valid, busy, frame_err, data_out);
            checks++;
            if (obs !== exp_v[i]) begin
                $display("FAIL basic_c%0d: got=%h expected=%h", i, obs, exp_v[i]);
                errors++;
            end
        end
    endtask

    // Bits 1,1,0,0 with en low on alternate cycles. During the en-low cycles sdi
    // toggles, and one of them carries a frame marker, which must be ignored.
    task automatic test_enable_gaps();
        logic [7:0] f_v = 8'b00001001;
        logic [7:0] s_v = 8'b10100101;
        logic [7:0] e_v = 8'b01010101;
        logic [6:0] exp_v [0:7];
        logic [6:0] obs;
        exp_v = '{7'h2A, 7'h2A, 7'h2A, 7'h2A, 7'h2A, 7'h2A, 7'h43, 7'h03};
        for (int i = 0; i < 8; i++) begin
            drive_cycle(f_v[i], s_v[i], e_v[i]);
            obs = {data_valid, busy, frame_err, data_out};
            $display("gaps c%0d f=%b s=%b e=%b -> dv=%b busy=%b fe=%b data=%h",
                     i, f_v[i], s_v[i], e_v[i], data_valid, busy, frame_err, data_out);
            checks++;
            if (obs !== exp_v[i]) begin
                $display("FAIL gaps_c%0d: got=%h expected=%h", i, obs, exp_v[i]);
                errors++;
            end
        end
    endtask

    // Sequence: frame, bits 1,1, then frame again, then bits 0,0,1,1.
    // Expect one error pulse, then a single word 4'hC.
    task automatic test_restart();
        logic [6:0] f_v = 7'b0000101;
        logic [6:0] s_v = 7'b0110011;
        logic [6:0] e_v = 7'b1111111;
        logic [6:0] exp_v [0:6];
        logic [6:0] obs;
        exp_v = '{7'h23, 7'h23, 7'h33, 7'h23, 7'h23, 7'h4C, 7'h0C};
        for (int i = 0; i < 7; i++) begin
            drive_cycle(f_v[i], s_v[i], e_v[i]);
            obs = {data_valid, busy, frame_err, data_out};
            $display("restart c%0d f=%b s=%b e=%b -> dv=%b busy=%b fe=%b data=%h",
                     i, f_v[i], s_v[i], e_v[i], data_valid, busy, frame_err, data_out);
            checks++;
            if (obs !== exp_v[i]) begin
                $display("FAIL restart_c%0d: got=%h expected=%h", i, obs, exp_v[i]);
                errors++;
            end
        end
    endtask

    // Two words back to back: 4'h5 then 4'hC. Frame is on cycles 0 and 4, with no gap.
    task automatic test_back_to_back();
        logic [8:0] f_v = 9'b000010001;
        logic [8:0] s_v = 9'b011000101;
        logic [8:0] e_v = 9'b111111111;
        logic [6:0] exp_v [0:8];
        logic [6:0] obs;
        exp_v = '{7'h2C, 7'h2C, 7'h2C, 7'h45, 7'h25, 7'h25, 7'h25, 7'h4C, 7'h0C};
        for (int i = 0; i < 9; i++) begin
            drive_cycle(f_v[i], s_v[i], e_v[i]);
            obs = {data_valid, busy, frame_err, data_out};
            $display("b2b c%0d f=%b s=%b e=%b -> dv=%b busy=%b fe=%b data=%h",
                     i, f_v[i], s_v[i], e_v[i], data_valid, busy, frame_err, data_out);
            checks++;
            if (obs !== exp_v[i]) begin
                $display("FAIL b2b_c%0d: got=%h expected=%h", i, obs, exp_v[i]);
                errors++;
            end
        end
    endtask

    // Reset is asserted after 2 bits of a word. After release, unframed bits are
    // dropped, and then a framed word 4'hF completes.
    task automatic test_reset_mid_word();
        logic [8:0] f_v = 9'b000010000;
        logic [8:0] s_v = 9'b011111111;
        logic [8:0] e_v = 9'b111111111;
        logic [6:0] exp_v [0:8];
        logic [6:0] obs;
        exp_v = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h20, 7'h20, 7'h4F, 7'h0F};
        drive_cycle(1'b1, 1'b1, 1'b1);
        drive_cycle(1'b0, 1'b1, 1'b1);
        obs = {data_valid, busy, frame_err, data_out};
        checks++;
        if (obs !== 7'h2C) begin
            $display("FAIL rst_mid_pre: got=%h expected=%h", obs, 7'h2C);
            errors++;
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        obs = {data_valid, busy, frame_err, data_out};
        $display("rst_mid assert -> dv=%b busy=%b fe=%b data=%h", data_valid, busy, frame_err, data_out);
        checks++;
        if (obs !== 7'h00) begin
            $display("FAIL rst_mid_async: got=%h expected=%h", obs, 7'h00);
            errors++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive_cycle(f_v[i], s_v[i], e_v[i]);
            obs = {data_valid, busy, frame_err, data_out};
            $display("rst_mid c%0d f=%b s=%b e=%b -> dv=%b busy=%b fe=%b data=%h",
                     i, f_v[i], s_v[i], e_v[i], data_valid, busy, frame_err, data_out);
            checks++;
            if (obs !== exp_v[i]) begin
                $display("FAIL rst_mid_c%0d: got=%h expected=%h", i, obs, exp_v[i]);
                errors++;
            end
        end
    endtask

    // Loopback from a behavioural right-shift/load register. On the load cycle
    // SO carries I[0], and frame is tied to load. Three shift cycles follow.
    task automatic test_loopback();
        logic [3:0] din = 4'h9;
        logic [3:0] up_r = 4'h0;
        logic [4:0] load_v = 5'b00001;
        logic [6:0] exp_v [0:4];
        logic [6:0] obs;
        logic so;
        exp_v = '{7'h2F, 7'h2F, 7'h2F, 7'h49, 7'h09};
        for (int i = 0; i < 5; i++) begin
            so = load_v[i] ? din[0] : up_r[0];
            drive_cycle(load_v[i], so, 1'b1);
            up_r = load_v[i] ? (din >> 1) : (up_r >> 1);
            obs = {data_valid, busy, frame_err, data_out};
            $display("loop c%0d load=%b so=%b -> dv=%b busy=%b fe=%b data=%h",
                     i, load_v[i], so, data_valid, busy, frame_err, data_out);
            checks++;
            if (obs !== exp_v[i]) begin
                $display("FAIL loop_c%0d: got=%h expected=%h", i, obs, exp_v[i]);
                errors++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_enable_gaps();
        test_restart();
        test_back_to_back();
        test_reset_mid_word();
        test_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_word_deserializer.md
# serial_word_deserializer

Serial-to-parallel word assembler that sits directly downstream of the right-shift/load register. It consumes that register's serial output, which is LSB-first, one bit per enabled clock. It uses a frame marker to align word boundaries and presents each completed N-bit word on a registered parallel output with a single-cycle valid strobe. It also flags frames that restart before the previous word completed.

## Interface
- N, default 4, word width in bits; legal range N >= 2
- clk  input  1  rising-edge clock
- reset_n  input  1  reset; asynchronous, active-low
- sdi  input  1  serial data in, LSB first; connects to upstream SO
- en  input  1  bit enable; sdi/frame are sampled only on edges where en=1
- frame  input  1  marks that sdi carries bit 0 of a new word (upstream drives it on its parallel-load cycle)
- data_out  output  N  last completed word, held until the next completion
- data_valid  output  1  one-cycle pulse: data_out was updated this cycle
- busy  output  1  a word is partially assembled (state SHIFT)
- frame_err  output  1  one-cycle pulse: frame arrived mid-word; partial word discarded

## Operation
- Internal state: FSM {IDLE, SHIFT}, shift register sr[N-1:0], bit counter cnt of width $clog2(N), with cnt counting bits already captured.
- Sampling: a "bit event" is a rising clk edge with en=1. When en=0 the block holds all state, and data_valid/frame_err go to 0.
- IDLE:
  - bit event with frame=1: sr <= {sdi, sr[N-1:1]}, cnt <= 1, go to SHIFT.
  - bit event with frame=0: ignored; the bit is dropped and there is no error.
- SHIFT, bit event with frame=0:
  - sr <= {sdi, sr[N-1:1]}, cnt <= cnt+1.
  - If cnt == N-1 (this is the last bit): data_out <= {sdi, sr[N-1:1]}, data_valid <= 1, cnt <= 0, go to IDLE.
- SHIFT, bit event with frame=1: the partial word is discarded and frame_err <= 1. This bit becomes bit 0 of a new word: sr shifted in, cnt <= 1, state remains SHIFT. data_out is unchanged and data_valid stays 0.
- Bit order: the first captured bit lands in data_out[0] and the Nth bit lands in data_out[N-1], matching the upstream right-shift order.
- Back-to-back words: frame may be asserted on the bit event immediately after the completing event, with no gap cycle required.
- busy = (state == SHIFT). It is a registered state decode with no combinational path from inputs.

## Timing
- Reset (async assert, synchronous-safe deassert by the system): state=IDLE, sr=0, cnt=0, data_out=0, data_valid=0, frame_err=0, busy=0.
- Reset asserted mid-word: the partial word is lost and no data_valid is produced. The first post-reset word requires frame.
- Latency: data_valid and the new data_out appear in the cycle after the edge that samples bit N-1, i.e. registered outputs only. With continuous en, frame on cycle k gives data_valid high during cycle k+N.
- data_valid and frame_err are each high for exactly one cycle per event and are never asserted together.
- Throughput: one word per N bit events with en held high.
- busy rises the cycle after the frame event and falls in the same cycle data_valid rises.

## Test plan
- Basic word, N=4, en=1: frame on first bit, sdi bits 0,1,0,1 → data_out=4'hA and data_valid=1 for one cycle, 4 cycles after frame; busy high for cycles 1-3.
- Enable gaps: same bits 1,1,0,0 with en=0 on alternate cycles, and sdi toggled while en=0 → data_out=4'h3, and data_valid comes exactly one cycle after the 4th enabled edge.
- Back-to-back: 4'h5 then 4'hC with frame on cycles 0 and 4 → data_valid pulses on cycles 4 and 8 with data_out 5 then C; no frame_err.
- Restart: frame, then bits 1,1 followed by frame with bits 0,0,1,1 → frame_err pulse one cycle after the second frame; a single data_valid with data_out=4'hC.
- Reset mid-word: assert reset_n=0 after 2 bits → all outputs 0 immediately. After release, bits with no frame produce nothing; a framed 4'hF yields data_valid with 4'hF.
- Loopback with upstream shift register (load=1 with I=4'h9, then 3 shift cycles, frame tied to load) → data_out=4'h9.
